// File: rtl/alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_ctrl
// Purpose  : Time-shares one ALU between two requesters using round-robin
//            arbitration, and returns tagged results over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_ctrl #(
    parameter int WIDTH       = 32,
    parameter int EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_z,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id,
    output logic             rsp_err,
    output logic             busy
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_exec  = 2'd1;
    localparam logic [1:0] c_st_resp  = 2'd2;

    localparam logic [3:0] c_cnt_load = 4'(EXEC_CYCLES - 1);

    localparam logic [2:0] c_op_and   = 3'b000;
    localparam logic [2:0] c_op_or    = 3'b001;
    localparam logic [2:0] c_op_add   = 3'b010;
    localparam logic [2:0] c_op_sub   = 3'b110;
    localparam logic [2:0] c_op_slt   = 3'b111;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_rr_ptr;
    logic             r_id;
    logic [3:0]       r_cnt;

    logic             w_grant0;
    logic             w_grant1;
    logic             w_accept;
    logic             w_sel_id;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic [2:0]       w_sel_op;
    logic             w_op_legal;
    logic             w_rsp_fire;

    // Grants exist only in IDLE; rr_ptr breaks ties when both are valid.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (r_state == c_st_idle) begin
            if (req0_valid && req1_valid) begin
                w_grant0 = ~r_rr_ptr;
                w_grant1 = r_rr_ptr;
            end else begin
                w_grant0 = req0_valid;
                w_grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    assign w_accept   = (req0_valid && w_grant0) || (req1_valid && w_grant1);
    assign w_sel_id   = w_grant1;
    assign w_sel_a    = w_grant1 ? req1_a  : req0_a;
    assign w_sel_b    = w_grant1 ? req1_b  : req0_b;
    assign w_sel_op   = w_grant1 ? req1_op : req0_op;
    assign w_rsp_fire = rsp_valid && rsp_ready;
    assign busy       = (r_state != c_st_idle);

    always_comb begin
        case (w_sel_op)
            c_op_and, c_op_or, c_op_add, c_op_sub, c_op_slt: w_op_legal = 1'b1;
            default:                                          w_op_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_state_nxt = w_op_legal ? c_st_exec : c_st_resp;
                end
            end
            c_st_exec: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = c_st_resp;
                end
            end
            c_st_resp: begin
                if (w_rsp_fire) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Illegal ops skip the ALU entirely, so alu_* keep their previous values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr  <= 1'b0;
            r_id      <= 1'b0;
            r_cnt     <= 4'd0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= 3'b000;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_rr_ptr <= ~w_sel_id;
                        r_id     <= w_sel_id;
                        if (w_op_legal) begin
                            alu_a  <= w_sel_a;
                            alu_b  <= w_sel_b;
                            alu_op <= w_sel_op;
                            r_cnt  <= c_cnt_load;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_data  <= '0;
                            rsp_id    <= w_sel_id;
                            rsp_err   <= 1'b1;
                        end
                    end
                end
                c_st_exec: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= alu_z;
                        rsp_id    <= r_id;
                        rsp_err   <= 1'b0;
                    end
                end
                c_st_resp: begin
                    if (w_rsp_fire) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_ctrl
// Purpose  : Self-checking bench for alu_share_ctrl with a behavioural ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_share_ctrl;

    typedef struct packed {
        logic [31:0] data;
        logic        id;
        logic        err;
    } rsp_t;

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic [31:0] alu_a, alu_b, alu_z, rsp_data;
    logic [2:0]  alu_op;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;

    logic        x_req0_valid, x_req0_ready, x_req1_valid, x_req1_ready;
    logic [31:0] x_req0_a, x_req0_b, x_req1_a, x_req1_b;
    logic [2:0]  x_req0_op, x_req1_op;
    logic [31:0] x_alu_a, x_alu_b, x_alu_z, x_rsp_data;
    logic [2:0]  x_alu_op;
    logic        x_rsp_valid, x_rsp_ready, x_rsp_id, x_rsp_err, x_busy;

    int   checks   = 0;
    int   failures = 0;
    rsp_t sb[$];
    logic acc_log[$];
    rsp_t exp0, exp1;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return {31'b0, ($signed(a) < $signed(b))};
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    assign alu_z   = alu_f(alu_a, alu_b, alu_op);
    assign x_alu_z = alu_f(x_alu_a, x_alu_b, x_alu_op);

    alu_share_ctrl #(.WIDTH(32), .EXEC_CYCLES(1)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_z(alu_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy)
    );

    alu_share_ctrl #(.WIDTH(32), .EXEC_CYCLES(4)) dut4 (
        .clk(clk), .reset(reset),
        .req0_valid(x_req0_valid), .req0_ready(x_req0_ready),
        .req0_a(x_req0_a), .req0_b(x_req0_b), .req0_op(x_req0_op),
        .req1_valid(x_req1_valid), .req1_ready(x_req1_ready),
        .req1_a(x_req1_a), .req1_b(x_req1_b), .req1_op(x_req1_op),
        .alu_a(x_alu_a), .alu_b(x_alu_b), .alu_op(x_alu_op), .alu_z(x_alu_z),
        .rsp_valid(x_rsp_valid), .rsp_ready(x_rsp_ready), .rsp_data(x_rsp_data),
        .rsp_id(x_rsp_id), .rsp_err(x_rsp_err), .busy(x_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: expectation queued on accept, compared on response handshake.
    always @(negedge clk) begin : monitor
        rsp_t e;
        if (!reset) begin
            if (req0_valid && req0_ready) begin
                sb.push_back(exp0);
                acc_log.push_back(1'b0);
            end
            if (req1_valid && req1_ready) begin
                sb.push_back(exp1);
                acc_log.push_back(1'b1);
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp: got id %0d data %h, expected no response",
                             rsp_id, rsp_data);
                end else begin
                    e = sb.pop_front();
                    check("sb_rsp_data", rsp_data, e.data);
                    check("sb_rsp_id", 32'(rsp_id), 32'(e.id));
                    check("sb_rsp_err", 32'(rsp_err), 32'(e.err));
                end
            end
        end
    end

    task automatic start_req(input logic id, input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] op, input logic [31:0] ed, input logic ee);
        if (!id) begin
            exp0 = '{ed, 1'b0, ee};
            req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
        end else begin
            exp1 = '{ed, 1'b1, ee};
            req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
        end
    endtask

    task automatic wait_accept(input logic id);
        bit got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = id ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: requester %0d got no ready in 50 cycles, expected ready", id);
        end
        @(posedge clk);
        #1;
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            done = !busy && (sb.size() == 0);
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout: busy=%0d pending=%0d, expected idle with none pending",
                     busy, sb.size());
        end
        tick();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t        vecs[9];
        logic [31:0] pa, pb;
        logic [2:0]  po;

        vecs[0] = '{1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 3'b000, 32'h00F000F0, 1'b0};
        vecs[1] = '{1'b1, 32'h12340000, 32'h00005678, 3'b001, 32'h12345678, 1'b0};
        vecs[2] = '{1'b0, 32'h00000001, 32'h00000002, 3'b011, 32'h00000000, 1'b1};
        vecs[3] = '{1'b1, 32'hFFFFFFFF, 32'h00000001, 3'b010, 32'h00000000, 1'b0};
        vecs[4] = '{1'b0, 32'h00000001, 32'h00000002, 3'b100, 32'h00000000, 1'b1};
        vecs[5] = '{1'b1, 32'h00000003, 32'h00000005, 3'b110, 32'hFFFFFFFE, 1'b0};
        vecs[6] = '{1'b0, 32'h00000001, 32'h00000002, 3'b101, 32'h00000000, 1'b1};
        vecs[7] = '{1'b1, 32'h00000005, 32'hFFFFFFFB, 3'b111, 32'h00000000, 1'b0};
        vecs[8] = '{1'b0, 32'h80000000, 32'h00000001, 3'b111, 32'h00000001, 1'b0};

        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        req0_a = '0; req0_b = '0; req0_op = '0; req1_a = '0; req1_b = '0; req1_op = '0;
        x_req0_valid = 1'b0; x_req1_valid = 1'b0; x_rsp_ready = 1'b1;
        x_req0_a = '0; x_req0_b = '0; x_req0_op = '0;
        x_req1_a = '0; x_req1_b = '0; x_req1_op = '0;
        #12;
        check("rst_alu_a", alu_a, 32'h0);
        check("rst_alu_op", 32'(alu_op), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_data", rsp_data, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ready0", 32'(req0_ready), 32'h0);
        tick();
        reset = 1'b0;

        // Single request, cycle by cycle
        start_req(1'b0, 32'd5, 32'd3, 3'b010, 32'd8, 1'b0);
        #1;
        check("single_ready0", 32'(req0_ready), 32'h1);
        check("single_ready1", 32'(req1_ready), 32'h0);
        wait_accept(1'b0);
        check("single_alu_a", alu_a, 32'd5);
        check("single_alu_b", alu_b, 32'd3);
        check("single_alu_op", 32'(alu_op), 32'h2);
        check("single_busy", 32'(busy), 32'h1);
        check("single_early_rsp", 32'(rsp_valid), 32'h0);
        tick();
        check("single_rsp_valid", 32'(rsp_valid), 32'h1);
        check("single_rsp_data", rsp_data, 32'd8);
        check("single_rsp_id", 32'(rsp_id), 32'h0);
        check("single_rsp_err", 32'(rsp_err), 32'h0);
        tick();
        check("single_done_busy", 32'(busy), 32'h0);
        check("single_done_valid", 32'(rsp_valid), 32'h0);

        // Table of ops, legal and illegal
        for (int i = 0; i < 9; i++) begin
            pa = alu_a; pb = alu_b; po = alu_op;
            start_req(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp_data, vecs[i].exp_err);
            wait_accept(vecs[i].id);
            wait_idle();
            if (vecs[i].exp_err) begin
                check("tbl_alu_a_hold", alu_a, pa);
                check("tbl_alu_b_hold", alu_b, pb);
                check("tbl_alu_op_hold", 32'(alu_op), 32'(po));
            end else begin
                check("tbl_alu_a", alu_a, vecs[i].a);
                check("tbl_alu_b", alu_b, vecs[i].b);
                check("tbl_alu_op", 32'(alu_op), 32'(vecs[i].op));
            end
        end

        // Illegal op: response one cycle after accept, ALU untouched
        pa = alu_a; pb = alu_b; po = alu_op;
        start_req(1'b1, 32'h11, 32'h22, 3'b011, 32'h0, 1'b1);
        wait_accept(1'b1);
        check("ill_rsp_valid", 32'(rsp_valid), 32'h1);
        check("ill_rsp_err", 32'(rsp_err), 32'h1);
        check("ill_rsp_data", rsp_data, 32'h0);
        check("ill_rsp_id", 32'(rsp_id), 32'h1);
        check("ill_alu_a", alu_a, pa);
        check("ill_alu_b", alu_b, pb);
        check("ill_alu_op", 32'(alu_op), 32'(po));
        wait_idle();

        // Backpressure
        rsp_ready = 1'b0;
        start_req(1'b0, 32'd7, 32'd9, 3'b010, 32'd16, 1'b0);
        wait_accept(1'b0);
        tick();
        start_req(1'b1, 32'd2, 32'd2, 3'b010, 32'd4, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
            check("bp_rsp_data", rsp_data, 32'd16);
            check("bp_rsp_id", 32'(rsp_id), 32'h0);
            check("bp_ready0", 32'(req0_ready), 32'h0);
            check("bp_ready1", 32'(req1_ready), 32'h0);
            check("bp_busy", 32'(busy), 32'h1);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_hs_ready1", 32'(req1_ready), 32'h0);
        tick();
        check("bp_post_valid", 32'(rsp_valid), 32'h0);
        check("bp_post_data_hold", rsp_data, 32'd16);
        check("bp_post_ready1", 32'(req1_ready), 32'h1);
        wait_accept(1'b1);
        wait_idle();

        // Async reset in the middle of EXEC
        start_req(1'b0, 32'd1, 32'd1, 3'b010, 32'd2, 1'b0);
        wait_accept(1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("ar_alu_a", alu_a, 32'h0);
        check("ar_alu_b", alu_b, 32'h0);
        check("ar_alu_op", 32'(alu_op), 32'h0);
        check("ar_rsp_valid", 32'(rsp_valid), 32'h0);
        check("ar_rsp_data", rsp_data, 32'h0);
        check("ar_rsp_id", 32'(rsp_id), 32'h0);
        check("ar_rsp_err", 32'(rsp_err), 32'h0);
        check("ar_busy", 32'(busy), 32'h0);
        sb.delete();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ar_no_rsp", 32'(rsp_valid), 32'h0);
        end

        // Contention: rr_ptr back at 0, grants alternate 0,1,0
        acc_log.delete();
        start_req(1'b0, 32'd10, 32'd4, 3'b110, 32'd6, 1'b0);
        start_req(1'b1, 32'hFFFFFFFF, 32'd1, 3'b111, 32'd1, 1'b0);
        #1;
        check("cont_ready0", 32'(req0_ready), 32'h1);
        check("cont_ready1", 32'(req1_ready), 32'h0);
        fork
            begin
                wait_accept(1'b0);
                start_req(1'b0, 32'd10, 32'd4, 3'b110, 32'd6, 1'b0);
                wait_accept(1'b0);
            end
            begin
                wait_accept(1'b1);
            end
        join
        wait_idle();
        check("cont_accepts", 32'(acc_log.size()), 32'd3);
        if (acc_log.size() == 3) begin
            check("cont_grant0", 32'(acc_log[0]), 32'h0);
            check("cont_grant1", 32'(acc_log[1]), 32'h1);
            check("cont_grant2", 32'(acc_log[2]), 32'h0);
        end

        // EXEC_CYCLES=4 instance
        x_req0_a = 32'hF0; x_req0_b = 32'h3C; x_req0_op = 3'b000; x_req0_valid = 1'b1;
        @(negedge clk);
        check("x4_ready0", 32'(x_req0_ready), 32'h1);
        tick();
        x_req0_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("x4_alu_a", x_alu_a, 32'hF0);
            check("x4_alu_b", x_alu_b, 32'h3C);
            check("x4_alu_op", 32'(x_alu_op), 32'h0);
            check("x4_early_rsp", 32'(x_rsp_valid), 32'h0);
            tick();
        end
        check("x4_rsp_valid", 32'(x_rsp_valid), 32'h1);
        check("x4_rsp_data", x_rsp_data, 32'h30);
        check("x4_rsp_err", 32'(x_rsp_err), 32'h0);
        tick();
        check("x4_done_busy", 32'(x_busy), 32'h0);

        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
